post_switch: RTL and testbench

//   In-line GMII-style receive filter on a single byte stream.
//   - select=0: every frame is forwarded unchanged.
//   - select=1: only ARP frames (EtherType 0x0806) are forwarded; all other frames are dropped.
//   - Output is the input delayed by a fixed pipeline long enough to read the EtherType

---
 rtl/post_switch.sv | 64 ++++++
 tb/tb_post_switch.sv | 84 ++++++++
 2 files changed

// File: rtl/post_switch.sv
// post_switch: GMII rx filter, all frames (select=0) or ARP only (select=1), DELAY+1 latency; in clk rst select up_data up_dv up_er, out down_data down_dv down_er
module post_switch #(
  parameter int DELAY = 22,
  parameter logic [15:0] ARP_TYPE = 16'h0806
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       select,
  input  logic [7:0] up_data,
  input  logic       up_dv,
  input  logic       up_er,
  output logic [7:0] down_data,
  output logic       down_dv,
  output logic       down_er
);
  logic [9:0] dl [DELAY];
  logic [9:0] tail;
  logic prev_dv, mode, prev_od, cur_keep, push, push_keep, pop, keep, osof;
  logic [4:0] idx, cur_idx;
  logic [7:0] type_hi;
  logic [1:0] q, q_n, cnt, cnt_pop, cnt_n;
  assign tail = dl[DELAY-1];
  assign cur_idx = (up_dv && !prev_dv) ? 5'd0 : idx;
  assign push = (up_dv && cur_idx == 5'd21) || (prev_dv && !up_dv && idx < 5'd22);
  assign push_keep = !mode || (up_dv && {type_hi, up_data} == ARP_TYPE);
  assign osof = tail[1] && !prev_od;
  assign pop = osof && cnt != 2'd0;
  assign keep = osof ? pop && q[0] : cur_keep;
  always_comb begin
    q_n = pop ? {1'b0, q[1]} : q;
    cnt_pop = cnt - {1'b0, pop};
    cnt_n = cnt_pop;
    if (push && cnt_pop != 2'd2) begin
      q_n[cnt_pop[0]] = push_keep;
      cnt_n = cnt_pop + 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) dl[i] <= '0;
      prev_dv <= 1'b0;
      mode <= 1'b0;
      idx <= '0;
      type_hi <= '0;
      q <= '0;
      cnt <= '0;
      prev_od <= 1'b0;
      cur_keep <= 1'b0;
      {down_data, down_dv, down_er} <= '0;
    end else begin
      dl[0] <= {up_data, up_dv, up_er};
      for (int i = 1; i < DELAY; i++) dl[i] <= dl[i-1];
      prev_dv <= up_dv;
      if (up_dv && !prev_dv) mode <= select;
      if (up_dv) idx <= cur_idx == 5'd31 ? cur_idx : cur_idx + 5'd1;
      if (up_dv && cur_idx == 5'd20) type_hi <= up_data;
      q <= q_n;
      cnt <= cnt_n;
      prev_od <= tail[1];
      cur_keep <= keep;
      {down_data, down_dv, down_er} <= keep ? tail : '0;
    end
  end
endmodule

// File: tb/tb_post_switch.sv
// tb_post_switch: scoreboard bench for post_switch
module tb_post_switch;
  logic clk = 0;
  logic rst = 1, select = 0, up_dv = 0, up_er = 0;
  logic [7:0] up_data = 0;
  logic [7:0] down_data;
  logic down_dv, down_er;
  logic [9:0] sb [$];
  int checks = 0, failures = 0, cyc = 0;
  logic sel = 0;
  always #5 clk = ~clk;
  post_switch dut (
    .clk(clk), .rst(rst), .select(select),
    .up_data(up_data), .up_dv(up_dv), .up_er(up_er),
    .down_data(down_data), .down_dv(down_dv), .down_er(down_er)
  );
  task automatic step(input logic [7:0] d, input logic v, input logic e, input logic r, input logic k);
    logic [9:0] want;
    @(posedge clk);
    #1;
    up_data = d;
    up_dv = v;
    up_er = e;
    rst = r;
    select = sel;
    cyc++;
    sb.push_back(k ? {d, v, e} : 10'd0);
    @(negedge clk);
    want = sb.size() == 24 ? sb.pop_front() : 10'd0;
    checks++;
    assert ({down_data, down_dv, down_er} === want) else begin
      failures++;
      $error("FAIL down cyc=%0d got=%h exp=%h", cyc, {down_data, down_dv, down_er}, want);
    end
    if (r) sb.delete();
  endtask
  task automatic frame(input int len, input bit arp, input int er_at, input int tog_at, input int gap);
    logic [7:0] b;
    logic k;
    k = !sel || (arp && len >= 14);
    for (int i = 0; i < 8 + len; i++) begin
      if (i == tog_at) sel = !sel;
      b = i < 7 ? 8'h55 : i == 7 ? 8'h5D : (arp && i == 20) ? 8'h08 : (arp && i == 21) ? 8'h06 : 8'(i - 8);
      step(b, 1'b1, i == er_at, 1'b0, k);
    end
    repeat (gap) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    repeat (3) step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    sel = 0;
    frame(60, 0, -1, -1, 12);
    frame(128, 0, 30, -1, 2);
    frame(60, 1, -1, -1, 12);
    sel = 1;
    frame(128, 0, -1, -1, 12);
    frame(60, 1, -1, -1, 12);
    sel = 1;
    frame(60, 1, -1, 10, 2);
    frame(128, 0, -1, -1, 12);
    sel = 1;
    frame(60, 0, -1, 10, 2);
    sel = 0;
    frame(60, 0, -1, 5, 12);
    sel = 1;
    frame(60, 0, -1, -1, 1);
    frame(128, 1, -1, -1, 1);
    frame(128, 0, -1, -1, 12);
    sel = 1;
    frame(6, 0, -1, -1, 5);
    frame(12, 1, -1, -1, 5);
    sel = 0;
    frame(0, 0, -1, -1, 5);
    frame(10, 0, 3, -1, 30);
    sel = 0;
    for (int i = 0; i < 40; i++)
      step(i < 7 ? 8'h55 : i == 7 ? 8'h5D : 8'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(60, 0, -1, -1, 30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
